// File: rtl/chunk_tail.sv
// chunk_tail: linearises N-dim memory offsets into flat DRAM addresses.
//
// Accepts one offset per transfer on the i_mofs rdy/ack port. It then spends
// DIM cycles on one multiply-accumulate per dimension:
//   acc += mofs[d] * pitch[id][d]
// The result, base[id] + acc, is presented on the o_addr rdy/ack port.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_mofs_rdy/i_mofs_ack   upstream offset handshake
//   i_mofs, i_id, i_which   offset, config id, which-select tag
//   i_end                   exclusive end id of the current config range
//   i_base, i_pitch         per-config base address and dimension pitches
//   o_addr_rdy/o_addr_ack   downstream address handshake
//   o_addr, o_id, o_which   linear address and its tags
//   o_last                  emitted id is the last of its group
//
// Optional: define CHUNK_TAIL_BOUND_CHECK_EN to add i_bound and o_oob.
// An address at or beyond i_bound[id] raises o_oob and is forced to 0.
module chunk_tail #(
    parameter int WBW    = 32,
    parameter int DIM    = 4,
    parameter int N_ICFG = 4,
    parameter int ABW    = 32,
    localparam int ICFG_BW = $clog2(N_ICFG + 1)
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_mofs_rdy,
    output logic                                 i_mofs_ack,
    input  logic                                 i_which,
    input  logic [DIM-1:0][WBW-1:0]              i_mofs,
    input  logic [ICFG_BW-1:0]                   i_id,
    input  logic [ICFG_BW-1:0]                   i_end,
    input  logic [N_ICFG-1:0][ABW-1:0]           i_base,
    input  logic [N_ICFG-1:0][DIM-1:0][ABW-1:0]  i_pitch,
`ifdef CHUNK_TAIL_BOUND_CHECK_EN
    input  logic [N_ICFG-1:0][ABW-1:0]           i_bound,
    output logic                                 o_oob,
`endif
    output logic                                 o_addr_rdy,
    input  logic                                 o_addr_ack,
    output logic [ABW-1:0]                       o_addr,
    output logic [ICFG_BW-1:0]                   o_id,
    output logic                                 o_which,
    output logic                                 o_last
);
    localparam int CW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

    state_t                   state_q, state_d;
    logic [DIM-1:0][WBW-1:0]  mofs_q, mofs_d;
    logic [ICFG_BW-1:0]       id_q, id_d, oid_q, oid_d;
    logic                     which_q, which_d, owhich_q, owhich_d;
    logic                     last_q, last_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [ABW-1:0]           acc_q, acc_d, addr_q, addr_d;
    logic [ABW-1:0]           base_sel, pitch_sel, acc_next, sum;
    logic [WBW-1:0]           mofs_sel;
    logic [ICFG_BW-1:0]       id_inc;
`ifdef CHUNK_TAIL_BOUND_CHECK_EN
    logic                     oob_q, oob_d;
    logic [ABW-1:0]           bound_sel;
`endif

    // Operand select by compare loops: an illegal id (>= N_ICFG) simply
    // selects zeros, so the FSM still completes without out-of-range reads.
    always_comb begin
        base_sel  = '0;
        pitch_sel = '0;
        mofs_sel  = '0;
`ifdef CHUNK_TAIL_BOUND_CHECK_EN
        bound_sel = '0;
`endif
        for (int k = 0; k < N_ICFG; k++) begin
            if (id_q == ICFG_BW'(k)) begin
                base_sel = i_base[k];
`ifdef CHUNK_TAIL_BOUND_CHECK_EN
                bound_sel = i_bound[k];
`endif
                for (int d = 0; d < DIM; d++)
                    if (cnt_q == CW'(d)) pitch_sel = i_pitch[k][d];
            end
        end
        for (int d = 0; d < DIM; d++)
            if (cnt_q == CW'(d)) mofs_sel = mofs_q[d];
    end

    assign acc_next = acc_q + ABW'(mofs_sel) * pitch_sel;
    assign sum      = base_sel + acc_next;
    // The last-of-group compare wraps at ICFG_BW bits on purpose.
    assign id_inc   = i_id + 1'b1;

    always_comb begin
        state_d    = state_q;
        mofs_d     = mofs_q;
        id_d       = id_q;
        which_d    = which_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        addr_d     = addr_q;
        oid_d      = oid_q;
        owhich_d   = owhich_q;
`ifdef CHUNK_TAIL_BOUND_CHECK_EN
        oob_d      = oob_q;
`endif
        i_mofs_ack = 1'b0;
        case (state_q)
            IDLE: begin
                i_mofs_ack = i_mofs_rdy;
                if (i_mofs_rdy) begin
                    mofs_d  = i_mofs;
                    id_d    = i_id;
                    which_d = i_which;
                    last_d  = (id_inc == i_end);
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(DIM - 1)) begin
`ifdef CHUNK_TAIL_BOUND_CHECK_EN
                    oob_d  = (sum >= bound_sel);
                    addr_d = (sum >= bound_sel) ? '0 : sum;
`else
                    addr_d = sum;
`endif
                    oid_d    = id_q;
                    owhich_d = which_q;
                    state_d  = OUT;
                end
            end
            OUT:     state_d = o_addr_ack ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            mofs_q   <= '0;
            id_q     <= '0;
            which_q  <= 1'b0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            addr_q   <= '0;
            oid_q    <= '0;
            owhich_q <= 1'b0;
`ifdef CHUNK_TAIL_BOUND_CHECK_EN
            oob_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mofs_q   <= mofs_d;
            id_q     <= id_d;
            which_q  <= which_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            addr_q   <= addr_d;
            oid_q    <= oid_d;
            owhich_q <= owhich_d;
`ifdef CHUNK_TAIL_BOUND_CHECK_EN
            oob_q    <= oob_d;
`endif
        end
    end

    assign o_addr_rdy = (state_q == OUT);
    assign o_addr     = addr_q;
    assign o_id       = oid_q;
    assign o_which    = owhich_q;
    assign o_last     = last_q;
`ifdef CHUNK_TAIL_BOUND_CHECK_EN
    assign o_oob      = oob_q;
`endif
endmodule

// File: doc/chunk_tail.md
Name: chunk_tail

Overview:
- Receiving end of the chunk-head memory-offset stream in the DMA pipeline.
- Accepts one N-dimensional memory offset (mofs) per transfer, tagged with config id and which-select.
- Linearises it into a flat address: per-id base plus the dot product of mofs and per-id dimension pitches, one multiply-accumulate per cycle.
- Presents the address with a last-of-group flag to the downstream DRAM request stage over a rdy/ack handshake.

Parameters:
WBW, 32, width of each mofs element (work bit width)
DIM, 4, number of memory dimensions
N_ICFG, 4, number of input configurations
ABW, 32, linear address width
ICFG_BW, $clog2(N_ICFG+1), config id width (derived, not overridable)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_mofs_rdy  input  1  upstream offset valid
i_mofs_ack  output  1  offset accepted
i_which  input  1  which-select tag accompanying offset
i_mofs  input  WBW x DIM  N-dim memory offset
i_id  input  ICFG_BW  config id of offset
i_end  input  ICFG_BW  exclusive end id of current config range
i_base  input  ABW x N_ICFG  per-config base address
i_pitch  input  ABW x N_ICFG x DIM  per-config dimension pitch
o_addr_rdy  output  1  linear address valid
o_addr_ack  input  1  downstream accepted
o_addr  output  ABW  linear address
o_id  output  ICFG_BW  id of emitted address
o_which  output  1  which-select of emitted address
o_last  output  1  emitted id is last of group

Behaviour:
- Reset (async, i_rst_n low): state IDLE, i_mofs_ack=0, o_addr_rdy=0, o_addr=0, o_id=0, o_which=0, o_last=0, accumulator=0, dim counter=0.
- Handshake rule, both ports: transfer when rdy and ack are high in the same cycle. Source holds data stable while rdy is high and not yet acked. Ack is never asserted without rdy.
- State IDLE:
  - i_mofs_ack = i_mofs_rdy (combinational).
  - On transfer: latch i_mofs, i_id, i_which; latch o_last = (i_id+1 == i_end) at this edge; clear accumulator and dim counter; go ACCUM.
- State ACCUM, DIM cycles, d = 0..DIM-1:
  - acc <= acc + mofs_r[d] * i_pitch[id_r][d], truncated mod 2^ABW.
  - mofs element is zero-extended to ABW before multiply; product is truncated to ABW.
  - After d = DIM-1: o_addr <= i_base[id_r] + acc_final (mod 2^ABW); o_id, o_which driven from latched values; go OUT.
  - i_mofs_ack = 0.
- State OUT:
  - o_addr_rdy = 1; all outputs held stable.
  - On o_addr_ack: go IDLE.
  - i_mofs_ack = 0; no accept in the ack cycle (no bypass).
- Latency: accept edge at cycle T gives o_addr_rdy high from cycle T+DIM+1. Peak throughput is one address per DIM+2 cycles.
- i_base, i_pitch and i_end are quasi-static: stable from accept until the output transfer. Changes while busy give an undefined address but never hang the FSM.
- Boundary conditions:
  - i_id >= N_ICFG: input illegal; address undefined; FSM still completes.
  - Address overflow wraps silently.
  - i_end = 0 with i_id = N_ICFG-1 and ICFG_BW wrap: compare is at ICFG_BW bits.
  - o_addr_ack held low indefinitely: block stalls in OUT and back-pressures upstream.
  - Reset asserted mid-ACCUM or mid-OUT: in-flight offset is dropped; IDLE on release; no output emitted.

Optional Feature:
- Macro: CHUNK_TAIL_BOUND_CHECK_EN.
- Enabled:
  - Adds input i_bound (ABW x N_ICFG) and output o_oob (1, reset 0).
  - In the cycle entering OUT: o_oob = (base+acc >= i_bound[id_r]); when set, o_addr is forced to 0. o_oob is held with the other outputs.
- Disabled: the port and logic are absent; addresses pass unchecked.

Test Plan:
- Basic linearise: DIM=4, pitch[1]={1,16,256,4096}, base[1]=0x1000, mofs={3,2,1,0}, id=1, end=2, which=1 -> o_addr=0x1123, o_id=1, o_which=1, o_last=1, rdy exactly 5 cycles after accept.
- Group sequence: ids 0,1,2 with i_end=3, base[k]=k*0x100, all pitches 1, mofs all 1 -> addrs 0x004, 0x104, 0x204; o_last=0,0,1.
- Back-pressure: o_addr_ack low 10 cycles in OUT -> o_addr stable, i_mofs_ack stays 0 with upstream rdy high; ack then next offset accepted following cycle.
- Wrap: ABW=32, base=0xFFFF_FFF0, mofs={0x20,0,0,0}, pitch0=1 -> o_addr=0x0000_0010.
- Reset mid-ACCUM: drop i_rst_n on cycle 2 of ACCUM -> all outputs 0 immediately; after release, new offset processes normally with no stale output.
- With CHUNK_TAIL_BOUND_CHECK_EN, bound[0]=0x100: addr 0x0FF -> o_oob=0, o_addr=0x0FF; addr 0x100 -> o_oob=1, o_addr=0.
